// File: rtl/axi_read_slave_lite.sv
// axi_read_slave_lite
// AXI read responder: queues AR requests in a small FIFO and returns R bursts
// one at a time, in order. Beat data is derived from the beat address so every
// beat is predictable without a storage array.
//
// Optional build macro: AXI_SLV_ERR_RESP_EN
//   defined   -> beats whose address is >= MEM_BYTES return SLVERR with rdata=0
//   undefined -> no out-of-range checking (MEM_BYTES unused)
// An arsize wider than the data bus always returns SLVERR on every beat.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   arid/araddr/arlen/arsize/arburst/arvalid/arready   AR channel
//   rid/rdata/rresp/rlast/rvalid/rready                R channel
// All outputs are registered.

`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module axi_read_slave_lite #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned AR_FIFO_DEPTH = 4,
    parameter int unsigned DATA_SEED     = 0,
    parameter int unsigned MEM_BYTES     = 4096
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [`ID_WIDTH-1:0]   arid,
    input  logic [`ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]             arlen,
    input  logic [2:0]             arsize,
    input  logic [1:0]             arburst,
    input  logic                   arvalid,
    output logic                   arready,
    output logic [`ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0]  rdata,
    output logic [1:0]             rresp,
    output logic                   rlast,
    output logic                   rvalid,
    input  logic                   rready
);

    localparam int unsigned ID_W       = `ID_WIDTH;
    localparam int unsigned ADDR_W     = `ADDR_WIDTH;
    localparam int unsigned PTR_W      = $clog2(AR_FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
    localparam int unsigned MAX_SIZE   = $clog2(BEAT_BYTES);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ar_req_t;

    typedef enum logic {
        S_IDLE,
        S_DATA
    } state_t;

    // Address of the beat following cur, for the burst type in use.
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0] cur,
        input logic [ADDR_W-1:0] start,
        input logic [7:0]        len,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        logic [ADDR_W-1:0] sz;
        logic [ADDR_W-1:0] inc;
        logic [ADDR_W-1:0] mask;
        sz   = ADDR_W'(1) << size;
        inc  = (cur & ~(sz - ADDR_W'(1))) + sz;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            2'b00:   next_addr = cur;
            2'b10:   next_addr = (start & ~mask) | (inc & mask);
            default: next_addr = inc;  // INCR and reserved
        endcase
    endfunction

    // Data pattern: bus-aligned beat address plus seed.
    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [ADDR_W-1:0] addr);
        beat_data = DATA_WIDTH'(addr & ~ADDR_W'(BEAT_BYTES - 1)) + DATA_WIDTH'(DATA_SEED);
    endfunction

    // Request FIFO storage (data only, no reset needed)
    ar_req_t fifo_q [AR_FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             arready_q, arready_d;

    // Burst context
    state_t            state_q,    state_d;
    logic [ID_W-1:0]   id_q,       id_d;
    logic [ADDR_W-1:0] start_q,    start_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [7:0]        len_q,      len_d;
    logic [2:0]        size_q,     size_d;
    logic [1:0]        burst_q,    burst_d;
    logic              size_err_q, size_err_d;
    logic [7:0]        beat_cnt_q, beat_cnt_d;

    // R outputs
    logic [ID_W-1:0]       rid_q,    rid_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic [1:0]            rresp_q,  rresp_d;
    logic                  rlast_q,  rlast_d;
    logic                  rvalid_q, rvalid_d;

    logic              push_c;
    logic              pop_c;
    ar_req_t           req_c;
    ar_req_t           head_c;
    logic              head_size_err_c;
    logic [ADDR_W-1:0] nxt_addr_c;
    logic              head_oob_c;
    logic              nxt_oob_c;
    logic              beat_err_c;

    assign req_c = '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};

    // Out-of-range detection for the head request and the next beat
`ifdef AXI_SLV_ERR_RESP_EN
    always_comb begin
        head_oob_c = (head_c.addr >= ADDR_W'(MEM_BYTES));
        nxt_oob_c  = (nxt_addr_c >= ADDR_W'(MEM_BYTES));
    end
`else
    logic [31:0] unused_mem_bytes;
    assign unused_mem_bytes = 32'(MEM_BYTES);
    always_comb begin
        head_oob_c = 1'b0;
        nxt_oob_c  = 1'b0;
    end
`endif

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        start_d    = start_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        size_err_d = size_err_q;
        beat_cnt_d = beat_cnt_q;
        rid_d      = rid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        rvalid_d   = rvalid_q;
        pop_c      = 1'b0;
        beat_err_c = 1'b0;

        push_c          = arvalid && arready_q;
        head_c          = fifo_q[rd_ptr_q];
        head_size_err_c = (head_c.size > 3'(MAX_SIZE));
        nxt_addr_c      = next_addr(addr_q, start_q, len_q, size_q, burst_q);

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    // Load the head request and present its first beat next cycle
                    pop_c      = 1'b1;
                    id_d       = head_c.id;
                    start_d    = head_c.addr;
                    addr_d     = head_c.addr;
                    len_d      = head_c.len;
                    size_d     = head_c.size;
                    burst_d    = head_c.burst;
                    size_err_d = head_size_err_c;
                    beat_cnt_d = 8'd0;
                    beat_err_c = head_size_err_c || head_oob_c;
                    rid_d      = head_c.id;
                    rdata_d    = beat_err_c ? '0 : beat_data(head_c.addr);
                    rresp_d    = beat_err_c ? 2'b10 : 2'b00;
                    rlast_d    = (head_c.len == 8'd0);
                    rvalid_d   = 1'b1;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        beat_err_c = size_err_q || nxt_oob_c;
                        addr_d     = nxt_addr_c;
                        beat_cnt_d = 8'(beat_cnt_q + 8'd1);
                        rdata_d    = beat_err_c ? '0 : beat_data(nxt_addr_c);
                        rresp_d    = beat_err_c ? 2'b10 : 2'b00;
                        rlast_d    = (8'(beat_cnt_q + 8'd1) == len_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d  = push_c ? PTR_W'(wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d  = pop_c  ? PTR_W'(rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d   = CNT_W'(count_q + CNT_W'(push_c) - CNT_W'(pop_c));
        arready_d = (count_d != CNT_W'(AR_FIFO_DEPTH));
    end

    // FIFO write port
    always_ff @(posedge aclk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= req_c;
        end
    end

    // State and output registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            arready_q  <= 1'b1;
            id_q       <= '0;
            start_q    <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            size_err_q <= 1'b0;
            beat_cnt_q <= '0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            rlast_q    <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            arready_q  <= arready_d;
            id_q       <= id_d;
            start_q    <= start_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            size_err_q <= size_err_d;
            beat_cnt_q <= beat_cnt_d;
            rid_q      <= rid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign arready = arready_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_axi_read_slave_lite.sv
// Directed bench for axi_read_slave_lite: reset state, single/INCR/WRAP/FIXED
// bursts, unaligned INCR, reserved burst type, oversize arsize, backpressure,
// queue full, reset mid-burst, and (with AXI_SLV_ERR_RESP_EN) out-of-range beats.

`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_axi_read_slave_lite;

    localparam int unsigned IDW = `ID_WIDTH;
    localparam int unsigned AW  = `ADDR_WIDTH;
    localparam int unsigned DW  = 32;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [IDW-1:0] arid = '0;
    logic [AW-1:0] araddr = '0;
    logic [7:0]    arlen = '0;
    logic [2:0]    arsize = '0;
    logic [1:0]    arburst = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [IDW-1:0] rid;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    axi_read_slave_lite #(
        .DATA_WIDTH   (DW),
        .AR_FIFO_DEPTH(4),
        .DATA_SEED    (0),
        .MEM_BYTES    (4096)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .arid   (arid),
        .araddr (araddr),
        .arlen  (arlen),
        .arsize (arsize),
        .arburst(arburst),
        .arvalid(arvalid),
        .arready(arready),
        .rid    (rid),
        .rdata  (rdata),
        .rresp  (rresp),
        .rlast  (rlast),
        .rvalid (rvalid),
        .rready (rready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge and hold it until accepted (bounded).
    task automatic send_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input bit hold);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        while (!arready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("ar_accept", 64'(arready), 64'd1);
        @(posedge aclk);
        @(negedge aclk);
        if (!hold) arvalid = 1'b0;
    endtask

    // Wait (bounded) for a beat with rready=1 and check it; returns at the
    // negedge after its handshake.
    task automatic rbeat(input string tag, input logic [IDW-1:0] id,
                         input logic [DW-1:0] data, input logic [1:0] resp,
                         input logic last);
        int n = 0;
        while (!rvalid && n < 20) begin
            @(negedge aclk);
            n++;
        end
        check({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        if (rvalid) begin
            check({tag, "_rid"},   64'(rid),   64'(id));
            check({tag, "_rdata"}, 64'(rdata), 64'(data));
            check({tag, "_rresp"}, 64'(rresp), 64'(resp));
            check({tag, "_rlast"}, 64'(rlast), 64'(last));
            @(negedge aclk);
        end
    endtask

    initial begin
        bit seen;

        // Reset state
        @(negedge aclk);
        @(negedge aclk);
        check("rst_arready", 64'(arready), 64'd1);
        check("rst_rvalid",  64'(rvalid),  64'd0);
        check("rst_rlast",   64'(rlast),   64'd0);
        check("rst_rid",     64'(rid),     64'd0);
        check("rst_rdata",   64'(rdata),   64'd0);
        check("rst_rresp",   64'(rresp),   64'd0);
        aresetn = 1'b1;
        @(negedge aclk);

        // Single read with latency: idle cycle, then the beat
        send_ar(4'd3, 32'h10, 8'd0, 3'd2, 2'b01, 1'b0);
        check("single_lat0", 64'(rvalid), 64'd0);
        @(negedge aclk);
        check("single_lat1", 64'(rvalid), 64'd1);
        rbeat("single", 4'd3, 32'h10, 2'b00, 1'b1);
        check("single_bubble", 64'(rvalid), 64'd0);

        // INCR
        send_ar(4'd1, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0);
        rbeat("incr0", 4'd1, 32'h100, 2'b00, 1'b0);
        rbeat("incr1", 4'd1, 32'h104, 2'b00, 1'b0);
        rbeat("incr2", 4'd1, 32'h108, 2'b00, 1'b0);
        rbeat("incr3", 4'd1, 32'h10C, 2'b00, 1'b1);

        // WRAP: boundary 16, wraps within 0x30..0x3F
        send_ar(4'd2, 32'h38, 8'd3, 3'd2, 2'b10, 1'b0);
        rbeat("wrap0", 4'd2, 32'h38, 2'b00, 1'b0);
        rbeat("wrap1", 4'd2, 32'h3C, 2'b00, 1'b0);
        rbeat("wrap2", 4'd2, 32'h30, 2'b00, 1'b0);
        rbeat("wrap3", 4'd2, 32'h34, 2'b00, 1'b1);

        // FIXED
        send_ar(4'd4, 32'h20, 8'd2, 3'd2, 2'b00, 1'b0);
        rbeat("fixed0", 4'd4, 32'h20, 2'b00, 1'b0);
        rbeat("fixed1", 4'd4, 32'h20, 2'b00, 1'b0);
        rbeat("fixed2", 4'd4, 32'h20, 2'b00, 1'b1);

        // Unaligned INCR: first beat data aligned down, then next aligned address
        send_ar(4'd8, 32'h102, 8'd1, 3'd2, 2'b01, 1'b0);
        rbeat("unal0", 4'd8, 32'h100, 2'b00, 1'b0);
        rbeat("unal1", 4'd8, 32'h104, 2'b00, 1'b1);

        // Reserved burst type behaves as INCR
        send_ar(4'd9, 32'h80, 8'd1, 3'd2, 2'b11, 1'b0);
        rbeat("rsvd0", 4'd9, 32'h80, 2'b00, 1'b0);
        rbeat("rsvd1", 4'd9, 32'h84, 2'b00, 1'b1);

        // arsize wider than the bus: SLVERR, rdata 0 on every beat
        send_ar(4'd10, 32'h40, 8'd1, 3'd3, 2'b01, 1'b0);
        rbeat("size0", 4'd10, 32'h0, 2'b10, 1'b0);
        rbeat("size1", 4'd10, 32'h0, 2'b10, 1'b1);

        // Backpressure mid-burst: outputs hold for 5 stalled cycles
        send_ar(4'd5, 32'h200, 8'd3, 3'd2, 2'b01, 1'b0);
        rbeat("bp0", 4'd5, 32'h200, 2'b00, 1'b0);
        rready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("bp_hold_rvalid", 64'(rvalid), 64'd1);
            check("bp_hold_rdata",  64'(rdata),  64'h204);
            check("bp_hold_rlast",  64'(rlast),  64'd0);
            check("bp_hold_rid",    64'(rid),    64'd5);
        end
        rready = 1'b1;
        rbeat("bp1", 4'd5, 32'h204, 2'b00, 1'b0);
        rbeat("bp2", 4'd5, 32'h208, 2'b00, 1'b0);
        rbeat("bp3", 4'd5, 32'h20C, 2'b00, 1'b1);

        // Queue full with rready low: one burst in service plus four queued
        rready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_ar(4'(i), 32'(32'h400 + 32'(i) * 32'h10), 8'd0, 3'd2, 2'b01, 1'b1);
        end
        check("full_arready", 64'(arready), 64'd0);
        arid = 4'd6; araddr = 32'h500;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("full_hold_arready", 64'(arready), 64'd0);
        end
        arvalid = 1'b0;
        rready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            rbeat("full_drain", 4'(i), 32'(32'h400 + 32'(i) * 32'h10), 2'b00, 1'b1);
        end
        check("full_arready_back", 64'(arready), 64'd1);

        // Reset mid-burst
        send_ar(4'd7, 32'h300, 8'd7, 3'd2, 2'b01, 1'b0);
        rbeat("mrst0", 4'd7, 32'h300, 2'b00, 1'b0);
        rbeat("mrst1", 4'd7, 32'h304, 2'b00, 1'b0);
        aresetn = 1'b0;
        #1;
        check("mrst_rvalid",  64'(rvalid),  64'd0);
        check("mrst_arready", 64'(arready), 64'd1);
        check("mrst_rlast",   64'(rlast),   64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            if (rvalid) seen = 1'b1;
        end
        check("mrst_no_beats", 64'(seen), 64'd0);

`ifdef AXI_SLV_ERR_RESP_EN
        // Second beat crosses MEM_BYTES
        send_ar(4'd11, 32'hFFC, 8'd1, 3'd2, 2'b01, 1'b0);
        rbeat("oob0", 4'd11, 32'hFFC, 2'b00, 1'b0);
        rbeat("oob1", 4'd11, 32'h0,   2'b10, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
